// File: rtl/watch_time_ctrl.sv
// Debounced two-key mm:ss timekeeper with RUN/SET_MIN/SET_SEC editing and a blink enable mask.
// Key edge to state/digit update is DEB_CYCLES+4 cycles; all outputs registered, no backpressure.
module watch_time_ctrl #(
    parameter int TICK_CYCLES  = 50_000_000,
    parameter int DEB_CYCLES   = 1_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    output logic [3:0] sec_l,
    output logic [3:0] sec_h,
    output logic [3:0] min_l,
    output logic [3:0] min_h,
    output logic [3:0] digit_en,
    output logic [1:0] set_mode,
    output logic       tick_1s,
    output logic       min_pulse
);
    localparam int TW = $clog2(TICK_CYCLES + 1);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_MIN = 2'd1,
        ST_SET_SEC = 2'd2
    } state_t;

    // Index 0 = mode key, index 1 = increment key.
    logic [1:0]    sync1_q, sync2_q, deb_q, deb_prev_q, press_q;
    logic [DW-1:0] deb_cnt_q [2];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            deb_q      <= 2'b11;
            deb_prev_q <= 2'b11;
            press_q    <= 2'b00;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
        end else begin
            sync1_q    <= {key_inc_n, key_mode_n};
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            press_q    <= deb_prev_q & ~deb_q;
            for (int k = 0; k < 2; k++) begin
                if (sync2_q[k] == deb_q[k]) begin
                    deb_cnt_q[k] <= '0;
                end else if (deb_cnt_q[k] == DEB_LAST) begin
                    deb_q[k]     <= sync2_q[k];
                    deb_cnt_q[k] <= '0;
                end else begin
                    deb_cnt_q[k] <= deb_cnt_q[k] + DW'(1);
                end
            end
        end
    end

    // Returns {wrap, hi, lo} for a 00..59 BCD pair.
    function automatic logic [8:0] bcd_inc(input logic [3:0] hi, input logic [3:0] lo);
        if (lo == 4'd9) begin
            if (hi == 4'd5) return {1'b1, 4'd0, 4'd0};
            return {1'b0, hi + 4'd1, 4'd0};
        end
        return {1'b0, hi, lo + 4'd1};
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    sec_l_q, sec_l_d, sec_h_q, sec_h_d, min_l_q, min_l_d, min_h_q, min_h_d;
    logic [3:0]    digit_en_q, digit_en_d;
    logic          tick_q, tick_d, minp_q, minp_d;
    logic          mode_p, inc_p;
    logic [8:0]    sec_inc, min_inc;

    always_comb begin
        mode_p  = press_q[0];
        inc_p   = press_q[1] & ~press_q[0];
        sec_inc = bcd_inc(sec_h_q, sec_l_q);
        min_inc = bcd_inc(min_h_q, min_l_q);

        state_d = state_q;
        if (mode_p) begin
            case (state_q)
                ST_RUN:     state_d = ST_SET_MIN;
                ST_SET_MIN: state_d = ST_SET_SEC;
                default:    state_d = ST_RUN;
            endcase
        end

        // A mode press leaving RUN swallows a coincident tick.
        tick_d     = (state_q == ST_RUN) && !mode_p && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = ((state_q == ST_RUN) && !mode_p && !tick_d) ? tick_cnt_q + TW'(1) : '0;

        sec_l_d = sec_l_q;
        sec_h_d = sec_h_q;
        min_l_d = min_l_q;
        min_h_d = min_h_q;
        minp_d  = 1'b0;
        if (tick_d) begin
            {sec_h_d, sec_l_d} = sec_inc[7:0];
            if (sec_inc[8]) begin
                {min_h_d, min_l_d} = min_inc[7:0];
                minp_d             = 1'b1;
            end
        end else if (inc_p && state_q == ST_SET_MIN) begin
            {min_h_d, min_l_d} = min_inc[7:0];
        end else if (inc_p && state_q == ST_SET_SEC) begin
            {sec_h_d, sec_l_d} = sec_inc[7:0];
        end

        if (state_d != state_q || state_q == ST_RUN) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            phase_d     = phase_q;
        end

        case (state_d)
            ST_SET_MIN: digit_en_d = {phase_d, phase_d, 2'b11};
            ST_SET_SEC: digit_en_d = {2'b11, phase_d, phase_d};
            default:    digit_en_d = 4'b1111;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_RUN;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            sec_l_q     <= 4'd0;
            sec_h_q     <= 4'd0;
            min_l_q     <= 4'd0;
            min_h_q     <= 4'd0;
            digit_en_q  <= 4'b1111;
            tick_q      <= 1'b0;
            minp_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            sec_l_q     <= sec_l_d;
            sec_h_q     <= sec_h_d;
            min_l_q     <= min_l_d;
            min_h_q     <= min_h_d;
            digit_en_q  <= digit_en_d;
            tick_q      <= tick_d;
            minp_q      <= minp_d;
        end
    end

    assign sec_l     = sec_l_q;
    assign sec_h     = sec_h_q;
    assign min_l     = min_l_q;
    assign min_h     = min_h_q;
    assign digit_en  = digit_en_q;
    assign set_mode  = state_q;
    assign tick_1s   = tick_q;
    assign min_pulse = minp_q;
endmodule

// File: doc/watch_time_ctrl.md
Name: watch_time_ctrl

Overview:
- Upstream timekeeping and setting stage for the 4-digit mm:ss seven-segment display scanner.
- Debounces two push keys and generates the 1 s tick.
- Runs a BCD minutes/seconds counter with a RUN/SET_MIN/SET_SEC state machine.
- Drives four BCD digits plus a per-digit enable mask, which the scanner uses to blink the field being set.

Parameters:
- TICK_CYCLES, 50_000_000, sys_clk cycles per 1 s tick.
- DEB_CYCLES, 1_000_000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz).
- BLINK_CYCLES, 12_500_000, cycles per blink-phase toggle in set modes (2 Hz blink).

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- key_mode_n  in  1  mode key, active-low, asynchronous to sys_clk.
- key_inc_n  in  1  increment key, active-low, asynchronous to sys_clk.
- sec_l  out  4  seconds units BCD, 0..9.
- sec_h  out  4  seconds tens BCD, 0..5.
- min_l  out  4  minutes units BCD, 0..9.
- min_h  out  4  minutes tens BCD, 0..5.
- digit_en  out  4  display enable, 1 = lit; bit0 = sec_l, bit1 = sec_h, bit2 = min_l, bit3 = min_h.
- set_mode  out  2  current state: 0 = RUN, 1 = SET_MIN, 2 = SET_SEC.
- tick_1s  out  1  one-cycle pulse per second in RUN.
- min_pulse  out  1  one-cycle pulse when seconds wrap 59->00 in RUN.

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset sys_rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: all digits 0; set_mode = 0; digit_en = 4'b1111; tick_1s = 0; min_pulse = 0. Tick, debounce and blink counters = 0; debounced key levels = 1; blink phase = 1.
- Key input path:
  - Each key passes a 2-FF synchronizer.
  - Debounce counter increments while the synchronized level differs from the debounced level, and clears when it matches.
  - When the counter reaches DEB_CYCLES-1, the debounced level updates.
  - A press pulse (1 cycle, internal) fires on the cycle after a debounced 1->0 transition.
  - Release generates no event.
  - A glitch shorter than DEB_CYCLES produces no pulse.
- Tick generation:
  - Counter runs 0..TICK_CYCLES-1 in RUN only.
  - tick_1s asserts on the cycle the counter equals TICK_CYCLES-1, and the counter wraps to 0.
  - In SET_MIN/SET_SEC the counter is held at 0, so time is frozen.
  - On return to RUN, the first tick arrives TICK_CYCLES cycles later.
- RUN state:
  - On tick, sec_l increments.
  - sec_l 9 -> 0 with sec_h+1; sec_h 5 and sec_l 9 -> 00 with min_l+1, and min_pulse asserts the same cycle as the digit update.
  - 59:59 -> 00:00, and min_pulse asserts.
  - Increment presses are ignored.
- FSM transitions on mode press: RUN -> SET_MIN -> SET_SEC -> RUN.
- SET_MIN:
  - Increment press advances minutes by 1 as BCD; 59 -> 00 wrap, with no carry into or out of seconds.
  - Seconds are untouched.
- SET_SEC:
  - Increment press advances seconds by 1; 59 -> 00 wrap, with no carry into minutes.
- digit_en and blink:
  - RUN: digit_en = 4'b1111.
  - SET_MIN: digit_en = {phase, phase, 1, 1}.
  - SET_SEC: digit_en = {1, 1, phase, phase}.
  - The blink counter counts 0..BLINK_CYCLES-1 and toggles phase at wrap.
  - On any state entry, the blink counter clears and phase = 1, so the edited field is lit immediately.
  - The blink counter is idle in RUN.
- Simultaneous events:
  - Mode and increment presses in the same cycle: mode wins; the increment is discarded.
  - Tick coinciding with a mode press leaving RUN: state change wins; the tick is discarded; tick_1s is not asserted and digits do not advance.
  - An increment press landing while the state changes is discarded.
- Mid-operation reset: returns immediately to the reset values above, including mid-debounce and mid-SET states. No press pulse is generated on reset release, even if a key is held low. A key held low through reset release is accepted after DEB_CYCLES and then produces a press pulse.
- Latency:
  - Key input falling edge to internal press pulse: DEB_CYCLES+3 cycles (2 sync + DEB_CYCLES count + 1 edge register).
  - Press pulse to digit/state update: 1 cycle.

Test Plan (TICK_CYCLES=100, DEB_CYCLES=8, BLINK_CYCLES=25):
- Reset then 6000 clocks in RUN -> display 01:00. Exactly one min_pulse, coincident with 00:59 -> 01:00; tick_1s period exactly 100 clocks.
- Preload 59:58 via set keys, return to RUN, 2 ticks -> 59:59 then 00:00. min_pulse on the wrap; digit_en = 4'b1111 throughout.
- key_mode_n low for 5 cycles (glitch) -> no state change. Held low for 20 cycles -> set_mode = 1 exactly DEB_CYCLES+4 clocks after the first low sample; digit_en bits[3:2] toggle every 25 clocks, starting at 1.
- In SET_MIN at min 58, three increment presses -> min 59, 00, 01. Seconds unchanged; tick_1s stays 0 for the entire SET period.
- Mode and increment debounced presses in the same cycle while in SET_MIN -> set_mode = 2, minutes unchanged.
- Assert sys_rst_n low during SET_SEC with blink phase 0 -> next clock shows all digits 0, set_mode 0, digit_en 4'b1111. Key held low across reset release -> set_mode becomes 1 after the debounce interval.
